// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default width and FSM states.
package div_pkg;
    localparam int DIV_N = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit and
// subtract the divisor if it fits.
module div_step #(
    parameter int N = div_pkg::DIV_N
) (
    input  logic [N-1:0] i_rem,
    input  logic         i_bit,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_rem,
    output logic         o_q_bit
);
    logic [N:0] w_shifted;
    logic [N:0] w_diff;
    logic       w_borrow;

    assign w_shifted = {i_rem, i_bit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    // The partial remainder is always below the divisor, so the shifted value is
    // below twice the divisor and the top bit of the N+1-bit difference is the borrow.
    assign w_borrow  = w_diff[N];
    assign o_q_bit   = ~w_borrow;
    assign o_rem     = w_borrow ? w_shifted[N-1:0] : w_diff[N-1:0];
endmodule

// File: rtl/udiv_seq.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Define UDIV_SEQ_SDIV_EN to add the is_signed input and two's complement support.
module udiv_seq
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
`ifdef UDIV_SEQ_SDIV_EN
    input  logic         is_signed,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);
    localparam int CW = $clog2(N) + 1;

    div_state_t r_state;
    div_state_t w_state_next;

    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_dvd;
    logic [N-1:0]  r_dvs;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_quotient;
    logic [N-1:0]  r_remainder;
    logic          r_div_zero;

    logic          w_accept;
    logic          w_zero;
    logic          w_last;
    logic          w_q_bit;
    logic [N-1:0]  w_rem_next;
    logic [N-1:0]  w_dvd_mag;
    logic [N-1:0]  w_dvs_mag;
    logic [N-1:0]  w_q_raw;
    logic [N-1:0]  w_q_final;
    logic [N-1:0]  w_r_final;

    assign w_accept = start && (r_state != CALC);
    assign w_zero   = (divisor == '0);
    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_q_raw  = {r_dvd[N-2:0], w_q_bit};

`ifdef UDIV_SEQ_SDIV_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_dvd_neg;
    logic w_dvs_neg;

    assign w_dvd_neg = is_signed & dividend[N-1];
    assign w_dvs_neg = is_signed & divisor[N-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;
    // Sign fixup is applied on the final iteration edge so it costs no cycles.
    assign w_q_final = r_neg_q ? -w_q_raw : w_q_raw;
    assign w_r_final = r_neg_r ? -w_rem_next : w_rem_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
    assign w_q_final = w_q_raw;
    assign w_r_final = w_rem_next;
`endif

    div_step #(.N(N)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[N-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = w_zero ? DONE : CALC;
            CALC:    if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? (w_zero ? DONE : CALC) : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == CALC);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_dvd <= w_dvd_mag;
            r_dvs <= w_dvs_mag;
            r_rem <= '0;
            if (w_zero) begin
                r_quotient  <= '0;
                r_remainder <= dividend;
                r_div_zero  <= 1'b1;
            end else begin
                r_div_zero  <= 1'b0;
            end
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt + CW'(1);
            r_dvd <= w_q_raw;
            r_rem <= w_rem_next;
            if (w_last) begin
                r_quotient  <= w_q_final;
                r_remainder <= w_r_final;
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;
endmodule

// File: tb/tb_udiv_seq.sv
// Self-checking bench for udiv_seq: directed corner cases plus random divides
// compared against plain SystemVerilog arithmetic.
module tb_udiv_seq;
    localparam int N = 64;
    localparam logic [63:0] MIN_VAL = 64'h8000_0000_0000_0000;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    udiv_seq #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef UDIV_SEQ_SDIV_EN
        .is_signed (is_signed),
`endif
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Reference: language-level division; signed follows truncation toward zero.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input bit sgn,
                         output logic [63:0] q, output logic [63:0] r, output bit dz);
        longint sa;
        longint sb;
        dz = 1'b0;
        if (b == 64'd0) begin
            q  = 64'd0;
            r  = a;
            dz = 1'b1;
        end else if (sgn) begin
            if (a == MIN_VAL && b == {64{1'b1}}) begin
                q = MIN_VAL;
                r = 64'd0;
            end else begin
                sa = a;
                sb = b;
                q  = sa / sb;
                r  = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic run_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input bit sgn, input int inject_at);
        logic [63:0] eq;
        logic [63:0] er;
        bit          edz;
        int          k;
        bit          busy_seen;
        model(a, b, sgn, eq, er, edz);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        k         = 0;
        busy_seen = 1'b0;
        while (!done && k < 200) begin
            if (busy) busy_seen = 1'b1;
            if (inject_at > 0 && k == inject_at - 1) begin
                start    = 1'b1;
                dividend = 64'd9;
                divisor  = 64'd3;
            end
            if (inject_at > 0 && k == inject_at) start = 1'b0;
            @(negedge clk);
            k++;
        end
        $display("div %s: %h / %h sgn=%0d -> q=%h r=%h dz=%0d latency=%0d", tag, a, b, sgn,
                 quotient, remainder, div_zero, k);
        check({tag, " latency"}, 64'(k), (b == 64'd0) ? 64'd0 : 64'(N));
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, edz});
        check({tag, " busy_seen"}, {63'd0, busy_seen}, {63'd0, (b != 64'd0)});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        bit          seen_done;
        bit          seen_busy;
        reset_n   = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 64'd0;
        divisor   = 64'd0;
        repeat (2) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset quotient", quotient, 64'd0);
        check("reset remainder", remainder, 64'd0);
        check("reset div_zero", {63'd0, div_zero}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_div("100/7", 64'd100, 64'd7, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("hold done low", {63'd0, done}, 64'd0);
        check("hold quotient", quotient, 64'd14);
        check("hold remainder", remainder, 64'd2);
        run_div("max/1", {64{1'b1}}, 64'd1, 1'b0, 0);
        run_div("5/9", 64'd5, 64'd9, 1'b0, 0);
        run_div("42/0", 64'd42, 64'd0, 1'b0, 0);
        run_div("100/7 after zero", 64'd100, 64'd7, 1'b0, 0);
        @(negedge clk);
        run_div("100/7 ignore 9/3", 64'd100, 64'd7, 1'b0, 10);

        // Asynchronous reset in the middle of a divide.
        dividend = 64'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        $display("reset mid-divide: busy=%0d done=%0d q=%h r=%h dz=%0d", busy, done,
                 quotient, remainder, div_zero);
        check("midreset busy", {63'd0, busy}, 64'd0);
        check("midreset done", {63'd0, done}, 64'd0);
        check("midreset quotient", quotient, 64'd0);
        check("midreset remainder", remainder, 64'd0);
        check("midreset div_zero", {63'd0, div_zero}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        check("post-reset done pulse", {63'd0, seen_done}, 64'd0);
        check("post-reset busy", {63'd0, seen_busy}, 64'd0);

        // Random unsigned divides, issued back to back from DONE.
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 5000)) : rnd64();
            case ($urandom_range(0, 7))
                0:       b = 64'd0;
                1, 2:    b = 64'($urandom_range(1, 1000));
                3, 4:    b = {32'd0, $urandom()} | 64'd1;
                default: b = rnd64();
            endcase
            run_div($sformatf("rand%0d", i), a, b, 1'b0, 0);
        end

`ifdef UDIV_SEQ_SDIV_EN
        @(negedge clk);
        run_div("-20/3", -64'd20, 64'd3, 1'b1, 0);
        run_div("MIN/-1", MIN_VAL, {64{1'b1}}, 1'b1, 0);
        run_div("-7/0 signed", -64'd7, 64'd0, 1'b1, 0);
        for (int i = 0; i < 16; i++) begin
            a = rnd64();
            b = ($urandom_range(0, 1) == 0) ? 64'($signed($urandom())) : rnd64();
            if (b == 64'd0) b = 64'd5;
            run_div($sformatf("srand%0d", i), a, b, 1'b1, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/udiv_seq.md
UDIV_SEQ -- requirements
Module: udiv_seq

Interface
REQ-001 SHALL have parameter N, default 64, giving the operand, quotient and remainder width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a divide; sampled only while busy=0.
REQ-005 SHALL have port dividend  input  N  numerator; captured on the accepted start.
REQ-006 SHALL have port divisor  input  N  denominator; captured on the accepted start.
REQ-007 SHALL have port busy  output  1  high while a divide is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; results are valid on that cycle.
REQ-009 SHALL have port quotient  output  N  registered result.
REQ-010 SHALL have port remainder  output  N  registered result.
REQ-011 SHALL have port div_zero  output  1  registered; set when the captured divisor was 0.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-013 SHALL assert busy only in CALC, and done only in DONE.
REQ-014 SHALL accept start in IDLE or DONE, capturing the operands at that edge (edge 0).
REQ-015 SHALL, when the accepted divisor is nonzero, enter CALC at edge 0.
REQ-016 SHALL, in CALC, perform one restoring shift-subtract iteration per cycle, MSB first, on edges 1..N.
REQ-017 SHALL register the results and enter DONE at edge N, so done is high from edge N to edge N+1.
REQ-018 SHALL compute the iteration subtraction in N+1 bits, keeping the partial remainder when the borrow is set and replacing it otherwise.
REQ-019 SHALL, on an accepted divisor of 0, go IDLE->DONE at edge 0 with quotient=0, remainder=dividend and div_zero=1.
REQ-020 SHALL clear div_zero on every accepted start whose divisor is nonzero.
REQ-021 SHALL ignore start while in CALC; the operands and the result in progress are unaffected.
REQ-022 SHALL go DONE->IDLE after one cycle when no start is present, and DONE->CALC directly on a back-to-back start.
REQ-023 SHALL hold quotient, remainder and div_zero stable from DONE until the next result is registered.

Reset
REQ-024 SHALL, while reset_n=0, force state=IDLE and busy=0, done=0, quotient=0, remainder=0, div_zero=0 immediately, independent of clk.
REQ-025 SHALL abandon any divide in progress when reset is asserted mid-CALC, and SHALL NOT produce a done pulse for it after reset is released.
REQ-026 SHALL begin sampling start on the first rising clk edge after reset_n deasserts.

Configuration
REQ-027 SHALL use the macro UDIV_SEQ_SDIV_EN to compile signed support in or out.
REQ-028 SHALL, with UDIV_SEQ_SDIV_EN defined, add input is_signed (1 bit, captured with start) and treat the operands as two's complement when is_signed=1.
REQ-029 SHALL, in signed mode, divide the operand magnitudes, then negate the quotient if the signs differ and negate the remainder if the dividend is negative; this fixup adds no cycles.
REQ-030 SHALL return, in signed mode, quotient=MIN and remainder=0 for MIN/-1, with no flag raised.
REQ-031 SHALL, without UDIV_SEQ_SDIV_EN, omit the is_signed port entirely and perform unsigned division only.

Structure
REQ-032 SHALL place the FSM state enum and the default width constant DIV_N=64 in package div_pkg.
REQ-033 SHALL implement one iteration as a separate combinational sub-module div_step: inputs partial remainder, next dividend bit and divisor; outputs new remainder and quotient bit.
REQ-034 SHALL keep the iteration counter at width $clog2(N)+1 and the result registers inside udiv_seq.

Verification
REQ-035 SHALL verify 100/7: done on the cycle after edge 64, quotient=14, remainder=2, div_zero=0.
REQ-036 SHALL verify 0xFFFF_FFFF_FFFF_FFFF/1 -> quotient=all ones, remainder=0; and 5/9 -> quotient=0, remainder=5.
REQ-037 SHALL verify 42/0: done on the cycle after edge 0, quotient=0, remainder=42, div_zero=1, busy never high.
REQ-038 SHALL verify a start of 9/3 pulsed at edge 10 of a running 100/7: it is ignored, and 100/7 completes with 14 rem 2.
REQ-039 SHALL verify reset_n=0 at edge 30 of a divide: all outputs are 0 at once, and no done pulse appears within 70 cycles after release.
REQ-040 SHALL verify, with UDIV_SEQ_SDIV_EN defined and is_signed=1: -20/3 -> quotient=-6, remainder=-2; MIN/-1 -> quotient=MIN, remainder=0.
